// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file writeback path: the architectural
// widths, the identity of each writeback source and the request bundle that
// a source presents to the arbiter.
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int REGISTER_FILE_ADDRESS_WIDTH = 5;
  localparam int RISC_V_DATA_WIDTH           = 32;
  localparam int REGISTER_FILE_NUM           = 32;

  // Requester slot assignment; the slot index is also the arbitration index.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_CSR  = 2'd2
  } wb_src_e;

  // One writeback request: destination index and value.
  // The index field cannot be called "reg" because that is a keyword.
  typedef struct packed {
    logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_num;
    logic [RISC_V_DATA_WIDTH-1:0]           data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered last-winner pointer.
//   clk, rst : clock, asynchronous active-high reset
//   req      : N request bits
//   advance  : a grant was accepted this cycle; move the pointer to it
//   grant    : one-hot grant (all zero when nothing requests)
// Search starts at ptr+1 and wraps, so the last winner has lowest priority.
// After reset ptr = N-1, which makes requester 0 the first in line.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[PW'(idx)]) begin
        grant[PW'(idx)] = 1'b1;
        grant_idx       = PW'(idx);
        found           = 1'b1;
      end
    end
  end

  // Pointer only moves on an accepted grant so an idle cycle keeps fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PW'(N - 1);
    end else if (advance && found) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between NUM_REQ writeback
// sources (0 = ALU, 1 = load, 2 = CSR/debug) and tracks pending writes so
// issue logic can detect read-after-write hazards.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-source handshake; ready is the arbiter grant
//   req_reg, req_data   : per-source destination/value, source i in slice i
//   issue_valid/rd      : a destination register is being issued
//   rs0_num, rs1_num    : hazard query indices
//   rs0_busy, rs1_busy  : queried register has a pending write
//   rf_reg_num_w, rf_w_data, rf_ctrl_reg_w : register file write port
//   busy_vec            : full pending-write scoreboard
//   conflict_cnt        : saturating count of cycles with 2+ requesters
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REGISTER_FILE_ADDRESS_WIDTH,
  parameter int DATA_W  = RISC_V_DATA_WIDTH,
  parameter int REG_NUM = REGISTER_FILE_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic [ADDR_W-1:0]         rs0_num,
  input  logic [ADDR_W-1:0]         rs1_num,
  output logic                      rs0_busy,
  output logic                      rs1_busy,
  output logic [ADDR_W-1:0]         rf_reg_num_w,
  output logic [DATA_W-1:0]         rf_w_data,
  output logic                      rf_ctrl_reg_w,
  output logic [REG_NUM-1:0]        busy_vec,
  output logic [15:0]               conflict_cnt
);

  logic [NUM_REQ-1:0] grant;
  logic               handshake;
  wb_req_t            winner;
  wb_req_t            wr_stage;
  logic               wr_en;
  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_next;

  // The write stage never stalls, so every grant is a completed handshake.
  assign req_ready = grant;
  assign handshake = |grant;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (handshake),
    .grant   (grant)
  );

  // Grant is one-hot, so selecting by plain assignment yields the winner.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        winner.reg_num = req_reg[i*ADDR_W +: ADDR_W];
        winner.data    = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // One-entry write stage. A write to x0 still takes the slot but never
  // raises the write enable; address/data hold when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_stage <= '0;
      wr_en    <= 1'b0;
    end else if (handshake) begin
      wr_stage <= winner;
      wr_en    <= (winner.reg_num != '0);
    end else begin
      wr_en    <= 1'b0;
    end
  end

  assign rf_reg_num_w  = wr_stage.reg_num;
  assign rf_w_data     = wr_stage.data;
  assign rf_ctrl_reg_w = wr_en;

  // Clear on the commit edge first, then set, so a producer issued on the
  // commit edge of an older write to the same register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (wr_en) begin
      busy_next[wr_stage.reg_num] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;
  assign rs0_busy = (rs0_num != '0) && busy[rs0_num];
  assign rs1_busy = (rs1_num != '0) && busy[rs1_num];

  // Contention counter saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (($countones(req_valid) >= 2) && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter. A reference model of the
// round-robin pointer, scoreboard and counter predicts each cycle; expected
// write-stage contents are queued at each predicted handshake and compared
// one cycle later when the write port presents them.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs0_num;
  logic [4:0]  rs1_num;
  logic        rs0_busy;
  logic        rs1_busy;
  logic [4:0]  rf_reg_num_w;
  logic [31:0] rf_w_data;
  logic        rf_ctrl_reg_w;
  logic [31:0] busy_vec;
  logic [15:0] conflict_cnt;

  typedef struct {
    logic        ctrl;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_exp_t;

  wr_exp_t sb[$];

  int          checks;
  int          fails;
  int          m_ptr;
  logic [31:0] m_busy;
  int          m_cnt;

  regfile_wb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .rs0_num       (rs0_num),
    .rs1_num       (rs1_num),
    .rs0_busy      (rs0_busy),
    .rs1_busy      (rs1_busy),
    .rf_reg_num_w  (rf_reg_num_w),
    .rf_w_data     (rf_w_data),
    .rf_ctrl_reg_w (rf_ctrl_reg_w),
    .busy_vec      (busy_vec),
    .conflict_cnt  (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setSource(input int i, input logic [4:0] rd, input logic [31:0] data);
    req_reg[i*5 +: 5]   = rd;
    req_data[i*32 +: 32] = data;
  endtask

  // Reset asserted mid-cycle: outputs must clear at once, model restarts.
  task automatic resetDut();
    @(negedge clk);
    rst         = 1'b1;
    req_valid   = 3'b000;
    issue_valid = 1'b0;
    #1;
    checkOutput("rst_ctrl", rf_ctrl_reg_w, 0);
    checkOutput("rst_reg", rf_reg_num_w, 0);
    checkOutput("rst_data", rf_w_data, 0);
    checkOutput("rst_busy", busy_vec, 0);
    checkOutput("rst_cnt", conflict_cnt, 0);
    checkOutput("rst_ready", req_ready, 0);
    sb.delete();
    m_ptr  = 2;
    m_busy = '0;
    m_cnt  = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs and the write port,
  // then advance the reference model across the rising edge.
  task automatic applyStimulus(input logic [2:0] v, input logic iv, input logic [4:0] ird,
                               input logic [4:0] q0, input logic [4:0] q1);
    wr_exp_t    e;
    logic       cur_ctrl;
    logic [4:0] cur_reg;
    logic [2:0] eg;
    logic       found;
    int         gidx;
    int         idx;
    @(negedge clk);
    req_valid   = v;
    issue_valid = iv;
    issue_rd    = ird;
    rs0_num     = q0;
    rs1_num     = q1;
    #1;
    cur_ctrl = 1'b0;
    cur_reg  = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("wr_ctrl", rf_ctrl_reg_w, e.ctrl);
      checkOutput("wr_reg", rf_reg_num_w, e.rd);
      checkOutput("wr_data", rf_w_data, e.data);
      cur_ctrl = e.ctrl;
      cur_reg  = e.rd;
    end else begin
      checkOutput("wr_idle", rf_ctrl_reg_w, 0);
    end
    eg    = '0;
    found = 1'b0;
    gidx  = 0;
    for (int off = 1; off <= 3; off++) begin
      idx = (m_ptr + off) % 3;
      if (!found && v[idx]) begin
        found   = 1'b1;
        gidx    = idx;
        eg[idx] = 1'b1;
      end
    end
    checkOutput("ready", req_ready, eg);
    checkOutput("rs0_busy", rs0_busy, (q0 != 0) && m_busy[q0]);
    checkOutput("rs1_busy", rs1_busy, (q1 != 0) && m_busy[q1]);
    @(posedge clk);
    if (found) begin
      m_ptr  = gidx;
      e.rd   = req_reg[gidx*5 +: 5];
      e.data = req_data[gidx*32 +: 32];
      e.ctrl = (e.rd != 0);
      sb.push_back(e);
    end
    if (cur_ctrl) m_busy[cur_reg] = 1'b0;
    if (iv && ird != 0) m_busy[ird] = 1'b1;
    if ((v[0] + v[1] + v[2]) >= 2 && m_cnt != 16'hFFFF) m_cnt++;
    #1;
    checkOutput("busy_vec", busy_vec, m_busy);
    checkOutput("conflict", conflict_cnt, m_cnt);
  endtask

  initial begin
    checks      = 0;
    fails       = 0;
    rst         = 1'b1;
    req_valid   = '0;
    req_reg     = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs0_num     = '0;
    rs1_num     = '0;
    m_ptr       = 2;
    m_busy      = '0;
    m_cnt       = 0;

    resetDut();

    // Lone ALU write to x5.
    setSource(0, 5'd5, 32'hDEADBEEF);
    applyStimulus(3'b001, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd0, 5'd0);

    // Full contention for six cycles from reset: 0,1,2,0,1,2.
    resetDut();
    setSource(0, 5'd1, 32'hA0A0_0001);
    setSource(1, 5'd2, 32'hB0B0_0002);
    setSource(2, 5'd3, 32'hC0C0_0003);
    for (int c = 0; c < 6; c++) applyStimulus(3'b111, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("conflict6", conflict_cnt, 6);

    // Issue x7, load writes x7 three cycles later; busy until commit edge.
    setSource(1, 5'd7, 32'h0000_0777);
    applyStimulus(3'b000, 1'b1, 5'd7, 5'd7, 5'd0);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd7, 5'd0);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd7, 5'd0);
    applyStimulus(3'b010, 1'b0, 5'd0, 5'd7, 5'd7);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd7, 5'd7);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd7, 5'd7);
    checkOutput("rs0_x7_clear", rs0_busy, 0);

    // Re-issue x9 on the commit edge of the older x9 write.
    setSource(2, 5'd9, 32'h9999_0009);
    applyStimulus(3'b000, 1'b1, 5'd9, 5'd9, 5'd0);
    applyStimulus(3'b100, 1'b0, 5'd0, 5'd9, 5'd0);
    applyStimulus(3'b000, 1'b1, 5'd9, 5'd9, 5'd0);
    checkOutput("busy9_kept", busy_vec[9], 1);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd9, 5'd9);

    // Write to x0 consumes the slot, advances pointer, never writes.
    resetDut();
    setSource(0, 5'd4, 32'h4444_0004);
    setSource(1, 5'd0, 32'h0000_1234);
    setSource(2, 5'd6, 32'h6666_0006);
    applyStimulus(3'b010, 1'b1, 5'd0, 5'd0, 5'd0);
    applyStimulus(3'b111, 1'b1, 5'd0, 5'd0, 5'd0);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_not_busy", busy_vec, 0);

    // Reset while the write stage holds a live entry.
    setSource(0, 5'd3, 32'h3333_0003);
    applyStimulus(3'b001, 1'b1, 5'd3, 5'd3, 5'd0);
    resetDut();
    setSource(0, 5'd10, 32'h1010_0010);
    setSource(1, 5'd11, 32'h1111_0011);
    setSource(2, 5'd12, 32'h1212_0012);
    applyStimulus(3'b111, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd0, 5'd0);

    // Random traffic against the model.
    for (int c = 0; c < 40; c++) begin
      for (int s = 0; s < 3; s++) setSource(s, 5'($urandom_range(0, 31)), $urandom);
      applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)));
    end
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback sources: ALU, load unit and CSR/debug.
- Round-robin arbitration with a valid/ready handshake.
- Registers the winner into a one-entry write stage that drives the register file write port (reg_num_w, w_data, ctrl_reg_w).
- Keeps a pending-write scoreboard so issue logic can detect read-after-write hazards on rs0/rs1.

Parameters:
- NUM_REQ, 3: number of writeback requesters; index 0 = ALU, 1 = load, 2 = CSR/debug.
- ADDR_W, REGISTER_FILE_ADDRESS_WIDTH (5): register index width.
- DATA_W, RISC_V_DATA_WIDTH (32): writeback data width.
- REG_NUM, REGISTER_FILE_NUM (32): number of architectural registers.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-source writeback request
- req_ready  output  NUM_REQ  per-source grant; handshake when valid&ready
- req_reg  input  NUM_REQ*ADDR_W  per-source destination index; source i occupies slice i
- req_data  input  NUM_REQ*DATA_W  per-source writeback data; source i occupies slice i
- issue_valid  input  1  an instruction with a destination register is issued this cycle
- issue_rd  input  ADDR_W  destination of the issued instruction
- rs0_num  input  ADDR_W  hazard query index 0
- rs1_num  input  ADDR_W  hazard query index 1
- rs0_busy  output  1  rs0_num has a pending write
- rs1_busy  output  1  rs1_num has a pending write
- rf_reg_num_w  output  ADDR_W  to register file reg_num_w
- rf_w_data  output  DATA_W  to register file w_data
- rf_ctrl_reg_w  output  1  to register file ctrl_reg_w
- busy_vec  output  REG_NUM  scoreboard state, for debug
- conflict_cnt  output  16  saturating count of contended cycles

Behaviour:
- Reset (async, rst=1): write stage cleared, so rf_ctrl_reg_w=0, rf_reg_num_w=0 and rf_w_data=0. busy_vec=0, conflict_cnt=0, req_ready=0. The RR pointer is set to NUM_REQ-1, so source 0 has top priority first.
- Arbitration (combinational):
  - Search order is ptr+1, ptr+2, … modulo NUM_REQ.
  - The first source with req_valid=1 gets req_ready=1; all other ready bits are 0.
  - No valid source means req_ready=0.
  - ready never depends on the source's own ready, only on valid and the pointer.
- The write stage always accepts, because the register file writes every cycle. Therefore ready = grant, with no backpressure beyond arbitration loss.
- A losing source must hold valid, reg and data stable until granted. Dropping valid before grant is allowed and is treated as a withdrawn request.
- Pointer update: ptr <= granted index, only on a cycle with a handshake. With no handshake, ptr holds.
- Write stage, on a handshake at edge N:
  - rf_reg_num_w and rf_w_data are registered from the winner.
  - rf_ctrl_reg_w=1 during cycle N+1, and the register file commits at edge N+1.
  - Latency from handshake to architectural update is 2 edges.
  - With no handshake, rf_ctrl_reg_w=0 next cycle; address and data hold their last values.
- x0: a writeback to index 0 is still granted, which consumes the slot and advances the pointer. rf_ctrl_reg_w is forced 0 for it.
- Scoreboard:
  - busy[issue_rd] sets at the edge where issue_valid=1 and issue_rd!=0.
  - busy[rf_reg_num_w] clears at the edge where rf_ctrl_reg_w=1, i.e. the register file commit edge.
  - Set and clear of the same index at the same edge: set wins, because a new producer is in flight.
  - busy[0] is always 0.
- Hazard outputs:
  - rs0_busy = busy_vec[rs0_num], and rs1_busy = busy_vec[rs1_num], both combinational.
  - Index 0 always reads 0.
  - There is no bypass: busy stays 1 through the commit cycle and clears on the commit edge.
- conflict_cnt increments at each edge where two or more req_valid bits are 1. It saturates at 0xFFFF and does not wrap.
- Reset mid-operation: the in-flight write-stage entry is dropped (no register file write) and all busy bits are cleared. The issue unit is reset together with this block.

Decomposition:
- Shared package (regfile_pkg) holds:
  - REGISTER_FILE_ADDRESS_WIDTH, RISC_V_DATA_WIDTH, REGISTER_FILE_NUM;
  - the wb_src_e enum (WB_ALU=0, WB_LOAD=1, WB_CSR=2);
  - a packed struct wb_req_t {reg, data}.
- One sub-module, rr_arbiter:
  - parameter N; inputs req[N], advance; output grant[N] one-hot;
  - owns the round-robin pointer.
- The scoreboard and write stage stay inline.

Test Plan:
- Single ALU request, reg 5, data 0xDEADBEEF at edge 1 → req_ready[0]=1 in cycle 1; cycle 2 has rf_ctrl_reg_w=1, rf_reg_num_w=5, rf_w_data=0xDEADBEEF; all other cycles rf_ctrl_reg_w=0.
- All three sources valid and held for 6 cycles from reset → grant order 0,1,2,0,1,2; conflict_cnt=6 afterwards; pending sources keep their data stable.
- Issue rd=7, then a load writeback to reg 7 granted 3 cycles later → rs0_busy(7)=1 from the edge after issue until the commit edge; 0 afterwards.
- Issue rd=9 in the same cycle that the write stage commits reg 9 → busy_vec[9] remains 1.
- Writeback to x0 with data 0x1234 → granted and pointer advances; rf_ctrl_reg_w stays 0; issue_rd=0 never sets busy.
- Assert rst while the write stage holds a valid entry → rf_ctrl_reg_w=0 immediately; busy_vec=0; after release, source 0 wins the first contention.
